// File: rtl/nth_root_iter.sv
// Iterative n-th root: builds floor(x^(1/n) * 2^FRAC_W) one bit at a time, MSB first,
// by raising each trial value to the n-th power and comparing it against x << (n*FRAC_W).
module nth_root_iter #(
    parameter  int IN_W   = 10,
    parameter  int FRAC_W = 10,
    parameter  int MAX_N  = 7,
    localparam int N_W    = $clog2(MAX_N + 1),
    localparam int OUT_W  = IN_W + FRAC_W,
    localparam int ACC_W  = MAX_N * OUT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [IN_W-1:0]  in_data,
    input  logic [N_W-1:0]   in_deg,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OUT_W-1:0] out_data,
    output logic             out_exact,
    output logic             out_err
);

    localparam int IDX_W  = $clog2(OUT_W);
    localparam int PROD_W = ACC_W + OUT_W;
    localparam logic [OUT_W-1:0] TOP_BIT = {1'b1, {(OUT_W-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, POW, CMP, DONE} state_t;

    state_t            state;
    logic [N_W-1:0]    n_reg;
    logic [N_W-1:0]    pow_cnt;
    logic [ACC_W-1:0]  target;
    logic [ACC_W-1:0]  accum;
    logic [OUT_W-1:0]  result;
    logic [OUT_W-1:0]  trial;
    logic [IDX_W-1:0]  idx;

    logic [OUT_W-1:0]  bit_mask;
    logic [OUT_W-1:0]  res_upd;
    logic [OUT_W-1:0]  next_trial;
    logic [PROD_W-1:0] prod;
    logic [ACC_W-1:0]  prod_sat;
    logic              acc_lt;
    logic              acc_eq;
    logic              deg_illegal;

    assign in_ready = (state == IDLE);

    always_comb begin
        bit_mask    = OUT_W'(1) << idx;
        acc_lt      = (accum < target);
        acc_eq      = (accum == target);
        res_upd     = (acc_lt || acc_eq) ? (result | bit_mask) : result;
        next_trial  = res_upd | (bit_mask >> 1);
        prod        = {{OUT_W{1'b0}}, accum} * {{ACC_W{1'b0}}, trial};
        // Once any bit above ACC_W is set the power is clamped; all-ones times trial stays clamped.
        prod_sat    = (|prod[PROD_W-1:ACC_W]) ? {ACC_W{1'b1}} : prod[ACC_W-1:0];
        deg_illegal = (in_deg == '0) || (32'(in_deg) > MAX_N);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            n_reg     <= '0;
            pow_cnt   <= '0;
            target    <= '0;
            accum     <= '0;
            result    <= '0;
            trial     <= '0;
            idx       <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_exact <= 1'b0;
            out_err   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        n_reg     <= in_deg;
                        pow_cnt   <= in_deg - N_W'(1);
                        target    <= ACC_W'(in_data) << (32'(in_deg) * FRAC_W);
                        result    <= '0;
                        idx       <= IDX_W'(OUT_W - 1);
                        trial     <= TOP_BIT;
                        accum     <= ACC_W'(TOP_BIT);
                        out_data  <= '0;
                        out_exact <= 1'b0;
                        out_err   <= 1'b0;
                        if (deg_illegal) begin
                            state     <= DONE;
                            out_valid <= 1'b1;
                            out_err   <= 1'b1;
                        end else if (in_data == '0) begin
                            state     <= DONE;
                            out_valid <= 1'b1;
                            out_exact <= 1'b1;
                        end else if (in_deg > N_W'(1)) begin
                            state <= POW;
                        end else begin
                            state <= CMP;
                        end
                    end
                end
                POW: begin
                    accum <= prod_sat;
                    if (pow_cnt == N_W'(1)) begin
                        state <= CMP;
                    end else begin
                        pow_cnt <= pow_cnt - N_W'(1);
                    end
                end
                CMP: begin
                    result <= res_upd;
                    if (acc_eq) begin
                        state     <= DONE;
                        out_valid <= 1'b1;
                        out_data  <= res_upd;
                        out_exact <= 1'b1;
                    end else if (idx == '0) begin
                        state     <= DONE;
                        out_valid <= 1'b1;
                        out_data  <= res_upd;
                        out_exact <= 1'b0;
                    end else begin
                        idx     <= idx - IDX_W'(1);
                        trial   <= next_trial;
                        accum   <= ACC_W'(next_trial);
                        pow_cnt <= n_reg - N_W'(1);
                        state   <= (n_reg > N_W'(1)) ? POW : CMP;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state     <= IDLE;
                        out_valid <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_nth_root_iter.sv
// Directed bench for nth_root_iter: table of radicand/degree vectors with hand-computed roots,
// plus hand sequences for back-pressure, mid-computation reset and out-of-range degrees.
module tb_nth_root_iter;

    localparam int IN_W   = 10;
    localparam int FRAC_W = 10;
    localparam int MAX_N  = 7;
    localparam int N_W    = 3;
    localparam int OUT_W  = 20;

    logic             clk;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [IN_W-1:0]  in_data;
    logic [N_W-1:0]   in_deg;
    logic             out_valid;
    logic             out_ready;
    logic [OUT_W-1:0] out_data;
    logic             out_exact;
    logic             out_err;

    // Second instance with a smaller MAX_N so that MAX_N+1 fits in the 3-bit degree port.
    logic             e_in_valid;
    logic             e_in_ready;
    logic [IN_W-1:0]  e_in_data;
    logic [N_W-1:0]   e_in_deg;
    logic             e_out_valid;
    logic             e_out_ready;
    logic [OUT_W-1:0] e_out_data;
    logic             e_out_exact;
    logic             e_out_err;

    nth_root_iter #(.IN_W(IN_W), .FRAC_W(FRAC_W), .MAX_N(MAX_N)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_deg(in_deg),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_exact(out_exact), .out_err(out_err)
    );

    nth_root_iter #(.IN_W(IN_W), .FRAC_W(FRAC_W), .MAX_N(5)) dut_small (
        .clk(clk), .rst(rst),
        .in_valid(e_in_valid), .in_ready(e_in_ready), .in_data(e_in_data), .in_deg(e_in_deg),
        .out_valid(e_out_valid), .out_ready(e_out_ready), .out_data(e_out_data),
        .out_exact(e_out_exact), .out_err(e_out_err)
    );

    typedef struct {
        logic [IN_W-1:0]  x;
        logic [N_W-1:0]   n;
        logic [OUT_W-1:0] data;
        logic             exact;
        logic             err;
        int               lat;
    } vec_t;

    vec_t vecs[10];
    int   checks;
    int   errors;
    int   lat;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Independent check: r^n <= x*2^(n*FRAC_W) < (r+1)^n at wide precision.
    function automatic bit floorOk(input logic [OUT_W-1:0] r, input logic [IN_W-1:0] x, input int n);
        logic [191:0] t, lo, hi;
        t  = 192'(x) << (n * FRAC_W);
        lo = 192'd1;
        hi = 192'd1;
        for (int i = 0; i < n; i++) begin
            lo = lo * 192'(r);
            hi = hi * (192'(r) + 192'd1);
        end
        return (lo <= t) && (hi > t);
    endfunction

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    // Accepts one request and counts rising edges after the accept edge until out_valid.
    task automatic applyStimulus(input logic [IN_W-1:0] x, input logic [N_W-1:0] n, output int cycles);
        int guard;
        guard = 0;
        while (!in_ready && guard < 200) begin
            @(posedge clk); #1;
            guard++;
        end
        checkOutput("in_ready before accept", 64'(in_ready), 64'd1);
        in_valid = 1'b1;
        in_data  = x;
        in_deg   = n;
        @(posedge clk); #1;
        in_valid = 1'b0;
        cycles   = 0;
        while (!out_valid && cycles < 400) begin
            @(posedge clk); #1;
            cycles++;
        end
        if (!out_valid) begin
            checks++;
            errors++;
            $display("[TB] FAIL timeout x=%0d n=%0d actual=no out_valid required=out_valid", x, n);
        end
    endtask

    task automatic releaseResult();
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        checkOutput("out_valid cleared", 64'(out_valid), 64'd0);
    endtask

    task automatic runVector(input vec_t v);
        string tag;
        tag = $sformatf("x=%0d n=%0d", v.x, v.n);
        applyStimulus(v.x, v.n, lat);
        checkOutput({tag, " data"},    64'(out_data),  64'(v.data));
        checkOutput({tag, " exact"},   64'(out_exact), 64'(v.exact));
        checkOutput({tag, " err"},     64'(out_err),   64'(v.err));
        checkOutput({tag, " latency"}, 64'(lat),       64'(v.lat));
        if (!v.err)
            checkOutput({tag, " floor bound"}, 64'(floorOk(out_data, v.x, int'(v.n))), 64'd1);
        releaseResult();
    endtask

    initial begin
        int seen;
        logic [OUT_W-1:0] held;
        checks      = 0;
        errors      = 0;
        rst         = 1'b1;
        in_valid    = 1'b0;
        in_data     = '0;
        in_deg      = '0;
        out_ready   = 1'b0;
        e_in_valid  = 1'b0;
        e_in_data   = '0;
        e_in_deg    = '0;
        e_out_ready = 1'b0;

        // Latency 0 here means out_valid is already high in the cycle right after the accept edge.
        vecs[0] = '{10'd27,   3'd3, 20'd3072,    1'b1, 1'b0, 30};
        vecs[1] = '{10'd2,    3'd2, 20'd1448,    1'b0, 1'b0, 40};
        vecs[2] = '{10'd5,    3'd1, 20'd5120,    1'b1, 1'b0, 10};
        vecs[3] = '{10'd0,    3'd4, 20'd0,       1'b1, 1'b0, 0};
        vecs[4] = '{10'd9,    3'd0, 20'd0,       1'b0, 1'b1, 0};
        vecs[5] = '{10'd16,   3'd4, 20'd2048,    1'b1, 1'b0, 36};
        vecs[6] = '{10'd1023, 3'd1, 20'd1047552, 1'b1, 1'b0, 10};
        vecs[7] = '{10'd1,    3'd7, 20'd1024,    1'b1, 1'b0, 70};
        vecs[8] = '{10'd1000, 3'd3, 20'd10240,   1'b1, 1'b0, 27};
        vecs[9] = '{10'd3,    3'd2, 20'd1773,    1'b0, 1'b0, 40};

        repeat (2) @(posedge clk);
        #1;
        checkOutput("reset out_valid", 64'(out_valid), 64'd0);
        checkOutput("reset out_data",  64'(out_data),  64'd0);
        checkOutput("reset out_exact", 64'(out_exact), 64'd0);
        checkOutput("reset out_err",   64'(out_err),   64'd0);
        checkOutput("reset in_ready",  64'(in_ready),  64'd1);
        rst = 1'b0;
        @(posedge clk); #1;

        for (int i = 0; i < 10; i++) runVector(vecs[i]);

        // Back-pressure: result held while out_ready is low, and new requests are ignored.
        applyStimulus(10'd1023, 3'd7, lat);
        checkOutput("hold latency", 64'(lat), 64'd140);
        checkOutput("hold floor bound", 64'(floorOk(out_data, 10'd1023, 7)), 64'd1);
        held     = out_data;
        in_valid = 1'b1;
        in_data  = 10'd5;
        in_deg   = 3'd1;
        for (int c = 0; c < 10; c++) begin
            @(posedge clk); #1;
            checkOutput($sformatf("hold c%0d data", c), 64'(out_data), 64'd2756);
            checkOutput($sformatf("hold c%0d flags", c),
                        64'({out_valid, in_ready, out_exact, out_err}), 64'b1000);
        end
        checkOutput("hold data stable", 64'(out_data), 64'(held));
        out_ready = 1'b1;
        @(posedge clk); #1;
        checkOutput("release no same-edge accept", 64'({out_valid, in_ready}), 64'b01);
        in_valid  = 1'b0;
        out_ready = 1'b0;

        // Reset in the middle of POW must drop the job without ever raising out_valid.
        in_valid = 1'b1;
        in_data  = 10'd1023;
        in_deg   = 3'd7;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        rst = 1'b1;
        #2;
        checkOutput("midreset out_valid", 64'(out_valid), 64'd0);
        checkOutput("midreset out_data",  64'(out_data),  64'd0);
        checkOutput("midreset in_ready",  64'(in_ready),  64'd1);
        @(posedge clk); #1;
        rst  = 1'b0;
        seen = 0;
        for (int c = 0; c < 160; c++) begin
            @(posedge clk); #1;
            if (out_valid) seen++;
        end
        checkOutput("no stale out_valid", 64'(seen), 64'd0);
        runVector(vecs[5]);

        // Degree MAX_N+1 on the small instance (MAX_N=5): 6 and 7 are illegal.
        for (int d = 6; d <= 7; d++) begin
            e_in_valid = 1'b1;
            e_in_data  = 10'd9;
            e_in_deg   = N_W'(d);
            @(posedge clk); #1;
            e_in_valid = 1'b0;
            checkOutput($sformatf("small n=%0d valid", d), 64'(e_out_valid), 64'd1);
            checkOutput($sformatf("small n=%0d err", d),   64'(e_out_err),   64'd1);
            checkOutput($sformatf("small n=%0d data", d),  64'(e_out_data),  64'd0);
            checkOutput($sformatf("small n=%0d exact", d), 64'(e_out_exact), 64'd0);
            e_out_ready = 1'b1;
            @(posedge clk); #1;
            e_out_ready = 1'b0;
            checkOutput($sformatf("small n=%0d ready", d), 64'(e_in_ready), 64'd1);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
